atm_frame_assembler: RTL and testbench
======================================

Name: atm_frame_assembler

Overview:
- Receive end of the ATM channel-sequencing path: consumes ADC DONE pulses together with the DONE-aligned channel tag (ATMCHSEL_DATA) and frame-end flag (LASTWORD) from the sequencer.
- Checks channel order against CHEN_sync and tags each sample with channel index and frame-boundary bits.
- Writes whole frames atomically into the sample FIFO: a frame is either fully written or fully dropped.
- Sits between the ADC/sequencer outputs and the sample FIFO write port, in the SAMPLE_CLK domain.

Parameters:
- DATA_W, 16, ADC sample width.
- FIFO_AW, 5, FIFO address width; FIFO_SPACE is FIFO_AW+1 bits wide.
- CNT_W, 8, width of the frame and drop counters.

Ports:
- SAMPLE_CLK  in  1  block clock; all logic on its rising edge.
- RST_sync  in  1  synchronous, active-high reset.
- ENSAMP_sync  in  1  sampling enable.
- CHEN_sync  in  8  enabled-channel mask.
- DONE  in  1  one-cycle conversion-complete strobe.
- ADC_DATA  in  DATA_W  sample, valid when DONE=1.
- ATMCHSEL_DATA  in  8  one-hot channel of the sample, valid when DONE=1.
- LASTWORD  in  1  marks the final channel of a frame, valid when DONE=1.
- FIFO_SPACE  in  FIFO_AW+1  free FIFO entries.
- FIFO_FULL  in  1  FIFO full.
- FIFO_WEN  out  1  write strobe.
- FIFO_WDATA  out  DATA_W+5  write word: {FSTART, FLAST, ch[2:0], data}.
- FRAME_CNT  out  CNT_W  frames committed; wraps.
- DROP_CNT  out  CNT_W  frames dropped; saturates at all-ones.
- SEQ_ERR  out  1  sticky channel-order or tag error.
- OVF_ERR  out  1  sticky write attempted while FIFO_FULL=1.

Behaviour:
- Reset (RST_sync=1 at a clock edge): FIFO_WEN=0, FIFO_WDATA=0, FRAME_CNT=0, DROP_CNT=0, SEQ_ERR=0, OVF_ERR=0, state=IDLE.
- Latency: a DONE sample at edge t appears as FIFO_WEN/FIFO_WDATA registered at edge t+1. DONE may be asserted every cycle (SAR mode); no back-pressure exists.
- Decode: ch = index of the one-hot ATMCHSEL_DATA bit. A zero or multi-hot tag with DONE=1 sets SEQ_ERR, the word is not written, and state goes to SYNC.
- nch = popcount(CHEN_sync); first_ch = lowest enabled channel index.
- IDLE: entered whenever ENSAMP_sync=0, which overrides all other state; no writes occur. On ENSAMP_sync=1, go to SYNC.
- SYNC: discard all DONE words. A DONE with LASTWORD=1 moves to RUN_START.
- RUN_START (next DONE is the frame head):
  - If ch!=first_ch: set SEQ_ERR, go to SYNC.
  - Else if FIFO_SPACE>=nch: write the word with FSTART=1, set exp=next enabled channel after ch, go to RUN.
  - Else: DROP_CNT++ (saturating), go to DROP.
  - If LASTWORD=1 on this same word (nch=1): write with FSTART=1 and FLAST=1, FRAME_CNT++, stay in RUN_START.
- RUN: on each DONE:
  - If ch!=exp: set SEQ_ERR, do not write, go to SYNC. The partial frame stays in the FIFO without FLAST; the reader delimits it by the next FSTART.
  - Else write; on LASTWORD=1 set FLAST=1, FRAME_CNT++, go to RUN_START.
- DROP: discard words; on DONE with LASTWORD=1 go to RUN_START.
- LASTWORD on a channel other than the highest enabled channel sets SEQ_ERR and forces SYNC.
- A write while FIFO_FULL=1 sets OVF_ERR, drops the word, and goes to DROP. The space check makes this a fault-only case.
- A CHEN_sync change, detected against a registered copy, forces SYNC on the next cycle regardless of DONE.
- If reset and DONE coincide, reset wins and the word is lost.

Decomposition:
- Shared package atm_pkg holds:
  - the state enum IDLE/SYNC/RUN_START/RUN/DROP;
  - the FIFO word field offsets (FSTART, FLAST, CH_LSB, DATA_LSB);
  - functions next_enabled_channel, lowest_enabled, onehot_to_idx and popcount8, shared with the sequencer.
- One sub-module, atm_tag_check: combinational decode of ATMCHSEL_DATA to {ch, valid_onehot, is_first, is_last_expected}.

Test Plan:
- CHEN=8'h0F, FIFO_SPACE=32, DONE every cycle through 3 frames, first LASTWORD used for sync -> writes ch0..ch3 per frame with FSTART on ch0 and FLAST on ch3, FRAME_CNT=2 after two full frames, no errors.
- CHEN=8'h10 (single channel), DONE every 6 cycles -> every word has FSTART=1 and FLAST=1, ch=4, FRAME_CNT increments on each DONE after sync.
- CHEN=8'h0F, FIFO_SPACE=3 at frame head -> no writes for that frame, DROP_CNT=1; with FIFO_SPACE=4 on the next frame it is fully written.
- Channel order ch0,ch2 with CHEN=8'h0F -> SEQ_ERR=1, ch2 word not written, resync at the next LASTWORD, and the following frame is written normally.
- ATMCHSEL_DATA=8'h03 with DONE=1 -> SEQ_ERR=1, no FIFO_WEN; ENSAMP_sync=0 mid-frame -> state IDLE and no further writes.
- RST_sync=1 mid-frame with DONE=1 -> next cycle FIFO_WEN=0, all counters and flags are 0, and the block waits in IDLE/SYNC.

Source files
------------

// File: rtl/atm_pkg.sv
// Shared types and helpers for the ATM channel-sequencing path (sequencer and frame assembler).
package atm_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSync,
    StRunStart,
    StRun,
    StDrop
  } atm_state_e;

  // Tag field sits directly above the sample; offsets below are relative to DATA_W.
  localparam int unsigned TAG_W    = 5;
  localparam int unsigned FSTART   = 4;
  localparam int unsigned FLAST    = 3;
  localparam int unsigned CH_LSB   = 0;
  localparam int unsigned DATA_LSB = 0;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  function automatic logic [2:0] onehot_to_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic [2:0] lowest_enabled(input logic [7:0] chen);
    logic [2:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (chen[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic [2:0] highest_enabled(input logic [7:0] chen);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (chen[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Wraps past channel 7 back to channel 0.
  function automatic logic [2:0] next_enabled_channel(input logic [7:0] chen,
                                                      input logic [2:0] ch);
    logic [2:0] idx;
    logic [2:0] c;
    logic       found;
    idx   = ch;
    found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      c = ch + 3'(i);
      if (!found && chen[c]) begin
        idx   = c;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/atm_frame_assembler_if.sv
// Sequencer-to-assembler sample stream plus the sample FIFO write port.
interface atm_frame_assembler_if
  import atm_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned FIFO_AW = 5
);
  logic                    DONE;
  logic [DATA_W-1:0]       ADC_DATA;
  logic [7:0]              ATMCHSEL_DATA;
  logic                    LASTWORD;
  logic [FIFO_AW:0]        FIFO_SPACE;
  logic                    FIFO_FULL;
  logic                    FIFO_WEN;
  logic [DATA_W+TAG_W-1:0] FIFO_WDATA;

  modport master (
    output DONE, ADC_DATA, ATMCHSEL_DATA, LASTWORD, FIFO_SPACE, FIFO_FULL,
    input  FIFO_WEN, FIFO_WDATA
  );

  modport slave (
    input  DONE, ADC_DATA, ATMCHSEL_DATA, LASTWORD, FIFO_SPACE, FIFO_FULL,
    output FIFO_WEN, FIFO_WDATA
  );
endinterface

// File: rtl/atm_tag_check.sv
// Combinational decode of the one-hot channel tag against the enabled-channel mask.
module atm_tag_check
  import atm_pkg::*;
(
  input  logic [7:0] ATMCHSEL_DATA,
  input  logic [7:0] CHEN_sync,
  output logic [2:0] ch,
  output logic       valid_onehot,
  output logic       is_first,
  output logic       is_last_expected
);
  assign ch               = onehot_to_idx(ATMCHSEL_DATA);
  assign valid_onehot     = (popcount8(ATMCHSEL_DATA) == 4'd1);
  assign is_first         = (ch == lowest_enabled(CHEN_sync));
  assign is_last_expected = (ch == highest_enabled(CHEN_sync));
endmodule

// File: rtl/atm_frame_assembler.sv
// Frame-atomic writer from the ADC/sequencer stream into the sample FIFO (SAMPLE_CLK domain).
module atm_frame_assembler
  import atm_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned FIFO_AW = 5,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               SAMPLE_CLK,
  input  logic               RST_sync,
  input  logic               ENSAMP_sync,
  input  logic [7:0]         CHEN_sync,
  atm_frame_assembler_if.slave bus,
  output logic [CNT_W-1:0]   FRAME_CNT,
  output logic [CNT_W-1:0]   DROP_CNT,
  output logic               SEQ_ERR,
  output logic               OVF_ERR
);
  localparam int unsigned SpaceW = FIFO_AW + 1;
  localparam int unsigned WordW  = DATA_W + TAG_W;

  atm_state_e       state_q, state_d;
  logic [2:0]       exp_q, exp_d;
  logic [7:0]       chen_q;
  logic             wen_q, wen_d;
  logic [WordW-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             seq_err_q, seq_err_d;
  logic             ovf_err_q, ovf_err_d;

  logic [2:0] ch;
  logic       valid_onehot, is_first, is_last_expected;
  logic       space_ok, do_write, fstart;

  atm_tag_check u_tag_check (
    .ATMCHSEL_DATA    (bus.ATMCHSEL_DATA),
    .CHEN_sync        (CHEN_sync),
    .ch               (ch),
    .valid_onehot     (valid_onehot),
    .is_first         (is_first),
    .is_last_expected (is_last_expected)
  );

  // Reserve room for the whole frame up front so a started frame never overflows.
  assign space_ok = (bus.FIFO_SPACE >= SpaceW'(popcount8(CHEN_sync)));

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    wen_d       = 1'b0;
    wdata_d     = wdata_q;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    seq_err_d   = seq_err_q;
    ovf_err_d   = ovf_err_q;
    do_write    = 1'b0;
    fstart      = 1'b0;

    if (!ENSAMP_sync) begin
      state_d = StIdle;
    end else if (CHEN_sync != chen_q) begin
      state_d = StSync;
    end else if (state_q == StIdle) begin
      state_d = StSync;
    end else if (bus.DONE) begin
      if (!valid_onehot ||
          (state_q != StSync && bus.LASTWORD && !is_last_expected)) begin
        seq_err_d = 1'b1;
        state_d   = StSync;
      end else begin
        case (state_q)
          StSync: begin
            if (bus.LASTWORD) state_d = StRunStart;
          end
          StRunStart: begin
            if (!is_first) begin
              seq_err_d = 1'b1;
              state_d   = StSync;
            end else if (space_ok) begin
              do_write = 1'b1;
              fstart   = 1'b1;
            end else begin
              if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_W'(1);
              state_d = bus.LASTWORD ? StRunStart : StDrop;
            end
          end
          StRun: begin
            if (ch != exp_q) begin
              seq_err_d = 1'b1;
              state_d   = StSync;
            end else begin
              do_write = 1'b1;
            end
          end
          StDrop: begin
            if (bus.LASTWORD) state_d = StRunStart;
          end
          default: ;
        endcase

        if (do_write) begin
          if (bus.FIFO_FULL) begin
            ovf_err_d = 1'b1;
            state_d   = StDrop;
          end else begin
            wen_d                            = 1'b1;
            wdata_d                          = '0;
            wdata_d[DATA_LSB +: DATA_W]      = bus.ADC_DATA;
            wdata_d[DATA_W + CH_LSB +: 3]    = ch;
            wdata_d[DATA_W + FLAST]          = bus.LASTWORD;
            wdata_d[DATA_W + FSTART]         = fstart;
            if (bus.LASTWORD) begin
              frame_cnt_d = frame_cnt_q + CNT_W'(1);
              state_d     = StRunStart;
            end else begin
              exp_d   = next_enabled_channel(CHEN_sync, ch);
              state_d = StRun;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge SAMPLE_CLK) begin
    if (RST_sync) begin
      state_q     <= StIdle;
      exp_q       <= '0;
      chen_q      <= CHEN_sync;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
      seq_err_q   <= 1'b0;
      ovf_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      chen_q      <= CHEN_sync;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      seq_err_q   <= seq_err_d;
      ovf_err_q   <= ovf_err_d;
    end
  end

  assign bus.FIFO_WEN   = wen_q;
  assign bus.FIFO_WDATA = wdata_q;
  assign FRAME_CNT      = frame_cnt_q;
  assign DROP_CNT       = drop_cnt_q;
  assign SEQ_ERR        = seq_err_q;
  assign OVF_ERR        = ovf_err_q;
endmodule

// File: tb/tb_atm_frame_assembler.sv
// Directed bench for atm_frame_assembler with hand-computed FIFO words and counters.
module tb_atm_frame_assembler;
  logic       clk;
  logic       rst;
  logic       ensamp;
  logic [7:0] chen;
  logic [7:0] frame_cnt;
  logic [7:0] drop_cnt;
  logic       seq_err;
  logic       ovf_err;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] dval = 16'h1000;

  atm_frame_assembler_if bus ();

  atm_frame_assembler dut (
    .SAMPLE_CLK  (clk),
    .RST_sync    (rst),
    .ENSAMP_sync (ensamp),
    .CHEN_sync   (chen),
    .bus         (bus),
    .FRAME_CNT   (frame_cnt),
    .DROP_CNT    (drop_cnt),
    .SEQ_ERR     (seq_err),
    .OVF_ERR     (ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.DONE = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      check_val("idle.wen", 32'(bus.FIFO_WEN), 32'd0);
    end
  endtask

  // One DONE word on channel ch; DONE stays high so back-to-back calls model SAR mode.
  task automatic xfer(input string tag, input int ch, input bit last, input bit wr, input bit fs);
    logic [20:0] w;
    bus.DONE          = 1'b1;
    bus.ATMCHSEL_DATA = 8'b1 << ch;
    bus.LASTWORD      = last;
    bus.ADC_DATA      = dval;
    w = {fs, last, 3'(ch), dval};
    step();
    check_val({tag, ".wen"}, 32'(bus.FIFO_WEN), 32'(wr));
    if (wr) check_val({tag, ".word"}, 32'(bus.FIFO_WDATA), 32'(w));
    dval = dval + 16'h0011;
  endtask

  // Channels 0..3 in order with LASTWORD on ch3 (CHEN = 8'h0F).
  task automatic frame4(input string tag, input bit wr);
    for (int c = 0; c < 4; c++) xfer(tag, c, c == 3, wr, c == 0);
  endtask

  initial begin
    rst               = 1'b1;
    ensamp            = 1'b0;
    chen              = 8'h0F;
    bus.DONE          = 1'b0;
    bus.ATMCHSEL_DATA = 8'h00;
    bus.LASTWORD      = 1'b0;
    bus.ADC_DATA      = 16'h0000;
    bus.FIFO_SPACE    = 6'd32;
    bus.FIFO_FULL     = 1'b0;
    step();
    step();
    check_val("rst.wen",   32'(bus.FIFO_WEN),   32'd0);
    check_val("rst.wdata", 32'(bus.FIFO_WDATA), 32'd0);
    check_val("rst.frame", 32'(frame_cnt),      32'd0);
    check_val("rst.drop",  32'(drop_cnt),       32'd0);
    check_val("rst.seq",   32'(seq_err),        32'd0);
    check_val("rst.ovf",   32'(ovf_err),        32'd0);
    rst    = 1'b0;
    ensamp = 1'b1;
    idle(2);

    // Four channels, DONE every cycle: first frame only syncs.
    frame4("sync0", 1'b0);
    frame4("f1", 1'b1);
    frame4("f2", 1'b1);
    check_val("t1.frame", 32'(frame_cnt), 32'd2);
    check_val("t1.seq",   32'(seq_err),   32'd0);
    check_val("t1.drop",  32'(drop_cnt),  32'd0);

    // Single channel 4, DONE every 6 cycles.
    chen = 8'h10;
    idle(1);
    xfer("one.sync", 4, 1'b1, 1'b0, 1'b0);
    idle(5);
    xfer("one.a", 4, 1'b1, 1'b1, 1'b1);
    check_val("one.frame_a", 32'(frame_cnt), 32'd3);
    idle(5);
    xfer("one.b", 4, 1'b1, 1'b1, 1'b1);
    check_val("one.frame_b", 32'(frame_cnt), 32'd4);

    // Insufficient space at frame head drops the whole frame.
    chen = 8'h0F;
    idle(1);
    frame4("sync1", 1'b0);
    bus.FIFO_SPACE = 6'd3;
    frame4("drop", 1'b0);
    check_val("sp.drop", 32'(drop_cnt), 32'd1);
    bus.FIFO_SPACE = 6'd4;
    frame4("sp4", 1'b1);
    check_val("sp.frame", 32'(frame_cnt), 32'd5);
    check_val("sp.drop2", 32'(drop_cnt),  32'd1);

    // Skipped channel: ch2 rejected, resync on ch3 LASTWORD.
    bus.FIFO_SPACE = 6'd32;
    xfer("ord.ch0", 0, 1'b0, 1'b1, 1'b1);
    xfer("ord.ch2", 2, 1'b0, 1'b0, 1'b0);
    check_val("ord.seq", 32'(seq_err), 32'd1);
    xfer("ord.resync", 3, 1'b1, 1'b0, 1'b0);
    frame4("ord.next", 1'b1);
    check_val("ord.frame", 32'(frame_cnt), 32'd6);

    // Reset coinciding with DONE mid-frame.
    xfer("rm.ch0", 0, 1'b0, 1'b1, 1'b1);
    rst = 1'b1;
    xfer("rm.ch1", 1, 1'b0, 1'b0, 1'b0);
    check_val("rm.wdata", 32'(bus.FIFO_WDATA), 32'd0);
    check_val("rm.frame", 32'(frame_cnt),      32'd0);
    check_val("rm.drop",  32'(drop_cnt),       32'd0);
    check_val("rm.seq",   32'(seq_err),        32'd0);
    check_val("rm.ovf",   32'(ovf_err),        32'd0);
    rst = 1'b0;
    idle(1);
    frame4("rm.sync", 1'b0);

    // Multi-hot tag.
    bus.DONE          = 1'b1;
    bus.ATMCHSEL_DATA = 8'h03;
    bus.LASTWORD      = 1'b0;
    step();
    check_val("mh.wen", 32'(bus.FIFO_WEN), 32'd0);
    check_val("mh.seq", 32'(seq_err),      32'd1);
    frame4("mh.sync", 1'b0);

    // Sampling disabled mid-frame.
    xfer("en.ch0", 0, 1'b0, 1'b1, 1'b1);
    xfer("en.ch1", 1, 1'b0, 1'b1, 1'b0);
    ensamp = 1'b0;
    xfer("en.ch2", 2, 1'b0, 1'b0, 1'b0);
    xfer("en.ch3", 3, 1'b1, 1'b0, 1'b0);
    ensamp = 1'b1;
    idle(1);
    frame4("en.after", 1'b0);
    check_val("en.frame", 32'(frame_cnt), 32'd0);

    // FIFO_FULL at frame head with space reported.
    bus.FIFO_FULL = 1'b1;
    frame4("ovf", 1'b0);
    check_val("ovf.flag",  32'(ovf_err),   32'd1);
    check_val("ovf.frame", 32'(frame_cnt), 32'd0);
    bus.FIFO_FULL = 1'b0;
    frame4("ovf.next", 1'b1);
    check_val("ovf.frame2", 32'(frame_cnt), 32'd1);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
